// File: rtl/svi_bank_pkg.sv
// rtl/svi_bank_pkg.sv - shared types and reset constants for the lane bank scheduler
package svi_bank_pkg;

    typedef enum logic [1:0] {
        F_X   = 2'd0,
        F_Y   = 2'd1,
        F_Z   = 2'd2,
        F_ALL = 2'd3
    } field_e;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
    } lane_t;

    localparam logic [7:0] LANE_RST_X = 8'hFF;
    localparam logic [7:0] LANE_RST_Y = 8'h00;
    localparam logic [7:0] LANE_RST_Z = 8'hFF;

    localparam lane_t LANE_RST = '{x: LANE_RST_X, y: LANE_RST_Y, z: LANE_RST_Z};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/svi_rr_arbiter.sv
// rtl/svi_rr_arbiter.sv - round-robin arbiter with combinational one-hot grant
module svi_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    output logic [NREQ-1:0] gnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] idx;
    logic          found;

    // Search from ptr upward with wrap; NREQ need not be a power of two.
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        idx     = '0;
        found   = 1'b0;
        if (enable) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!found) begin
                    idx = PW'((int'(ptr) + k) % NREQ);
                    if (req[idx]) begin
                        gnt[idx] = 1'b1;
                        ptr_nxt  = PW'((int'(idx) + 1) % NREQ);
                        found    = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/svi_bank_scheduler.sv
// rtl/svi_bank_scheduler.sv - lane array with arbitrated writes, clear sweep and registered read-back
module svi_bank_scheduler
    import svi_bank_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int NLANE = 8,
    localparam int LW    = $clog2(NLANE)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ*LW-1:0] i_lane,
    input  logic [NREQ*2-1:0]  i_field,
    input  logic [NREQ*8-1:0]  i_data,
    output logic [NREQ-1:0]    o_gnt,
    input  logic               i_clr,
    output logic               o_busy,
    output logic               o_clr_done,
    input  logic [LW-1:0]      i_rd_lane,
    output logic [7:0]         o_a,
    output logic [7:0]         o_b,
    output logic [7:0]         o_c
);

    state_e        state;
    state_e        state_nxt;
    logic [LW-1:0] cnt;
    lane_t         lanes [NLANE];
    logic          arb_en;

    logic          wr_en;
    logic [LW-1:0] wr_lane;
    field_e        wr_field;
    logic [7:0]    wr_data;

    svi_rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .req    (i_req),
        .enable (arb_en),
        .gnt    (o_gnt)
    );

    // A clear request wins over any write in the cycle it is accepted.
    always_comb begin
        state_nxt = state;
        arb_en    = 1'b0;
        case (state)
            IDLE: begin
                if (i_clr) begin
                    state_nxt = CLR;
                end else begin
                    arb_en = 1'b1;
                end
            end
            CLR: begin
                if (cnt == LW'(NLANE - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (i_clr) begin
                    state_nxt = CLR;
                end else begin
                    state_nxt = IDLE;
                    arb_en    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign o_busy     = (state == CLR);
    assign o_clr_done = (state == DONE);

    always_comb begin
        wr_en    = |(o_gnt & i_req);
        wr_lane  = '0;
        wr_field = F_X;
        wr_data  = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (o_gnt[r]) begin
                wr_lane  = i_lane[r*LW +: LW];
                wr_field = field_e'(i_field[r*2 +: 2]);
                wr_data  = i_data[r*8 +: 8];
            end
        end
    end

    // Power-of-two NLANE lets the sweep counter wrap back to zero on its own.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (state == CLR) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NLANE; i++) begin
                lanes[i] <= LANE_RST;
            end
        end else if (state == CLR) begin
            lanes[cnt] <= LANE_RST;
        end else if (wr_en) begin
            case (wr_field)
                F_X:   lanes[wr_lane].x <= wr_data;
                F_Y:   lanes[wr_lane].y <= wr_data;
                F_Z:   lanes[wr_lane].z <= wr_data;
                F_ALL: lanes[wr_lane]   <= '{x: wr_data, y: wr_data, z: wr_data};
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_a <= '0;
            o_b <= '0;
            o_c <= '0;
        end else begin
            o_a <= lanes[i_rd_lane].x;
            o_b <= lanes[i_rd_lane].y;
            o_c <= lanes[i_rd_lane].z;
        end
    end

endmodule

// File: tb/tb_svi_bank_scheduler.sv
// tb/tb_svi_bank_scheduler.sv - directed and random checks against a lane bank reference model
module tb_svi_bank_scheduler;

    localparam int NREQ  = 4;
    localparam int NLANE = 8;
    localparam int LW    = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*LW-1:0] lane;
    logic [NREQ*2-1:0]  field;
    logic [NREQ*8-1:0]  data;
    logic [NREQ-1:0]    gnt;
    logic               clr;
    logic               busy;
    logic               clr_done;
    logic [LW-1:0]      rd_lane;
    logic [7:0]         oa, ob, oc;

    always #5 clk = ~clk;

    svi_bank_scheduler #(.NREQ(NREQ), .NLANE(NLANE)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_lane    (lane),
        .i_field   (field),
        .i_data    (data),
        .o_gnt     (gnt),
        .i_clr     (clr),
        .o_busy    (busy),
        .o_clr_done(clr_done),
        .i_rd_lane (rd_lane),
        .o_a       (oa),
        .o_b       (ob),
        .o_c       (oc)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: lane contents, pointer, sweep phase (0 idle, 1 clearing, 2 done).
    logic [7:0]      mx [NLANE];
    logic [7:0]      my [NLANE];
    logic [7:0]      mz [NLANE];
    logic [7:0]      ma, mb, mc;
    int              mptr, mstate, mcnt;
    logic [NREQ-1:0] mgnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NLANE; i++) begin
            mx[i] = 8'hFF;
            my[i] = 8'h00;
            mz[i] = 8'hFF;
        end
        ma = 0; mb = 0; mc = 0;
        mptr = 0; mstate = 0; mcnt = 0; mgnt = '0;
    endtask

    function automatic logic [NREQ-1:0] exp_gnt();
        logic [NREQ-1:0] g;
        g = '0;
        if (mstate != 1 && !clr) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g == '0 && req[(mptr + k) % NREQ]) g[(mptr + k) % NREQ] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic set_req(input int r, input int l, input int f, input logic [7:0] d);
        lane[r*LW +: LW] = LW'(l);
        field[r*2 +: 2]  = 2'(f);
        data[r*8 +: 8]   = d;
    endtask

    // Compare all outputs mid-cycle, then advance the model across the rising edge.
    task automatic step(input string tag);
        int l, f;
        logic [7:0] d;
        @(negedge clk);
        mgnt = exp_gnt();
        check({tag, "_gnt"}, 32'(gnt), 32'(mgnt));
        check({tag, "_busy"}, 32'(busy), 32'(mstate == 1));
        check({tag, "_done"}, 32'(clr_done), 32'(mstate == 2));
        check({tag, "_abc"}, {8'h0, oa, ob, oc}, {8'h0, ma, mb, mc});
        @(posedge clk);
        ma = mx[rd_lane]; mb = my[rd_lane]; mc = mz[rd_lane];
        if (mstate == 1) begin
            mx[mcnt] = 8'hFF; my[mcnt] = 8'h00; mz[mcnt] = 8'hFF;
            if (mcnt == NLANE - 1) begin
                mstate = 2;
                mcnt = 0;
            end else begin
                mcnt++;
            end
        end else if (clr) begin
            mstate = 1;
        end else begin
            mstate = 0;
            for (int r = 0; r < NREQ; r++) begin
                if (mgnt[r]) begin
                    l = int'(lane[r*LW +: LW]);
                    f = int'(field[r*2 +: 2]);
                    d = data[r*8 +: 8];
                    if (f == 0 || f == 3) mx[l] = d;
                    if (f == 1 || f == 3) my[l] = d;
                    if (f == 2 || f == 3) mz[l] = d;
                    mptr = (r + 1) % NREQ;
                end
            end
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; lane = '0; field = '0; data = '0; clr = 1'b0; rd_lane = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        rd_lane = 3'd5;
        step("rst");
        step("rst_rd");
        check("rst_a", 32'(oa), 32'h0FF);
        check("rst_c", 32'(oc), 32'h0FF);

        for (int r = 0; r < NREQ; r++) set_req(r, 2, 3, 8'(r * 8'h11));
        req = 4'b1111;
        repeat (4) step("rr4");
        req = '0;
        rd_lane = 3'd2;
        step("rr4_rd");
        step("rr4_rd");
        check("lane2_x", 32'(oa), 32'h33);
        check("lane2_z", 32'(oc), 32'h33);

        set_req(1, 7, 1, 8'hA5);
        rd_lane = 3'd7;
        req = 4'b0010;
        step("wr_a5");
        req = '0;
        step("wr_a5_old");
        step("wr_a5_new");
        check("lane7_y", 32'(ob), 32'hA5);

        set_req(0, 0, 0, 8'h77);
        req = 4'b0001;
        clr = 1'b1;
        step("clr_start");
        clr = 1'b0;
        repeat (10) step("clr_run");
        req = '0;

        for (int l = 0; l < NLANE; l++) begin
            set_req(0, l, 3, 8'h5A);
            req = 4'b0001;
            step("prewr");
        end
        req = '0;
        clr = 1'b1;
        step("clr2");
        clr = 1'b0;
        repeat (3) step("clr2_run");
        rst_n = 1'b0;
        #2;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_done", 32'(clr_done), 32'h0);
        check("midrst_a", 32'(oa), 32'h0);
        rst_n = 1'b1;
        model_reset();
        for (int l = 0; l < NLANE; l++) begin
            rd_lane = LW'(l);
            step("postrst");
        end
        step("postrst");

        set_req(0, 1, 0, 8'h11);
        set_req(2, 4, 0, 8'h22);
        req = 4'b0101;
        repeat (6) step("alt");
        set_req(2, 6, 0, 8'h99);
        step("drop");
        req = '0;
        rd_lane = 3'd6;
        step("drop_rd");
        step("drop_rd");
        check("lane6_x", 32'(oa), 32'hFF);

        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (req[r] && !mgnt[r]) begin
                    if ($urandom_range(0, 15) == 0) req[r] = 1'b0;
                end else begin
                    req[r] = 1'($urandom_range(0, 1));
                    set_req(r, int'($urandom_range(0, NLANE - 1)), int'($urandom_range(0, 3)),
                            8'($urandom_range(0, 255)));
                end
            end
            clr     = ($urandom_range(0, 31) == 0);
            rd_lane = LW'($urandom_range(0, NLANE - 1));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/svi_bank_scheduler.md
Name: svi_bank_scheduler

Overview:
- Owns an array of NLANE lane records, each holding three 8-bit fields x/y/z, in the same style as the interface-array register lanes.
- Shares write access to the lane array among NREQ requesters through a round-robin arbiter.
- Runs a clear sequencer that sweeps every lane back to its default values.
- Provides a registered read-back port that drives o_a/o_b/o_c from one selected lane.

Parameters:
- NREQ, 4, number of write requesters (2..8).
- NLANE, 8, number of lanes (power of 2, ≥2).
- LW, $clog2(NLANE), lane index width (derived; not overridden).

Ports:
- i_clk  input  1  single clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req  input  NREQ  per-requester write request; held until granted.
- i_lane  input  NREQ*LW  per-requester target lane, slice r = requester r.
- i_field  input  NREQ*2  per-requester field select: 0=x, 1=y, 2=z, 3=all.
- i_data  input  NREQ*8  per-requester write data.
- o_gnt  output  NREQ  one-hot grant; write commits on the edge where o_gnt[r]&i_req[r].
- i_clr  input  1  pulse; starts a clear sweep.
- o_busy  output  1  high while a clear sweep is in progress.
- o_clr_done  output  1  one-cycle pulse after the last lane is cleared.
- i_rd_lane  input  LW  read-back lane select.
- o_a  output  8  registered x of the selected lane.
- o_b  output  8  registered y of the selected lane.
- o_c  output  8  registered z of the selected lane.

Behaviour:
- Reset, asynchronous on i_rst_n low:
  - every lane is set to x=8'hFF, y=8'h00, z=8'hFF.
  - rr pointer=0, state=IDLE, sweep counter=0.
  - o_a/o_b/o_c=0, o_busy=0, o_clr_done=0.
  - Reset mid-sweep abandons the sweep; no o_clr_done pulse is generated.
- FSM states: IDLE, CLR, DONE.
  - IDLE→CLR when i_clr=1. i_clr has priority over requests: o_gnt=0 in that cycle.
  - CLR: each cycle, lane[cnt] is set to defaults and cnt increments. When cnt==NLANE-1, go to DONE. o_busy=1 in CLR. o_gnt=0 throughout CLR.
  - DONE: o_clr_done=1 (registered, one cycle), o_busy=0, grants allowed; next state IDLE. i_clr in DONE is accepted the same as in IDLE.
  - i_clr during CLR is ignored; the sweep is not restarted.
- Arbitration (IDLE and DONE only):
  - o_gnt is combinational from i_req and the rr pointer.
  - Search starts at index ptr and wraps modulo NREQ; the first active request wins.
  - On a grant to requester r, ptr ← (r+1) mod NREQ. With no request, ptr holds.
  - At most one grant per cycle.
- Write on the grant edge:
  - field 0/1/2 writes x/y/z of lane i_lane[r] with i_data[r]; field 3 writes all three fields with the same data.
  - Other lanes and other fields are unchanged.
- Read-back:
  - o_a/o_b/o_c ← lane[i_rd_lane] every cycle, 1-cycle latency.
  - A read of the lane written on the same edge returns the old value; the new value appears one cycle later.
  - Reads continue during CLR.
- Requester protocol: once i_req[r] is high, i_lane/i_field/i_data for r must stay stable until granted. Dropping i_req before the grant is permitted; no write occurs.

Decomposition:
- Package svi_bank_pkg holds:
  - field_e enum (F_X, F_Y, F_Z, F_ALL).
  - lane_t struct {x,y,z: logic[7:0]}.
  - constants LANE_RST_X=8'hFF, LANE_RST_Y=8'h00, LANE_RST_Z=8'hFF.
  - state_e (IDLE, CLR, DONE).
- Sub-module svi_rr_arbiter, parameter NREQ:
  - inputs: i_clk, i_rst_n, req, enable.
  - output: one-hot gnt.
  - contains the pointer register.
- The lane array, clear FSM and read-back stay in svi_bank_scheduler.

Test Plan:
- Reset release, i_rd_lane=5 → after 1 cycle o_a=8'hFF, o_b=8'h00, o_c=8'hFF; o_busy=0, o_gnt=0.
- i_req=4'b1111 held for 4 cycles, all targeting lane 2 field 3, data r*8'h11 → grants in order 0001,0010,0100,1000; final lane2 x=y=z=8'h33.
- Requester 1 writes lane 7 field 1 with 8'hA5 while i_rd_lane=7 → o_b=8'h00 in the cycle after the write edge, then 8'hA5.
- i_clr pulse with i_req[0]=1 in the same cycle → o_gnt=0, o_busy high for 8 cycles, o_clr_done one pulse at cycle 9, then grant 0001.
- Lanes pre-written to 8'h5A, then i_rst_n low mid-sweep at cnt=3 → all lanes at defaults immediately, no o_clr_done, state IDLE.
- Requests alternate 4'b0101 for 6 cycles → grants 0001,0100,0001,0100,…; pointer wrap verified. Requester 2 drops its request before grant → no write to its lane.
